// File: rtl/regf_pkg.sv
// Shared constants and types for the integer register file and its writeback scheduler.
package regf_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;
    localparam int unsigned XLEN       = 32;

    typedef logic [REG_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter. Search starts at ptr+1 (mod N) and grants the first
// asserted request. The caller owns the pointer register.
module rr_arbiter #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            any
);

    // Rotating priority search, first hit after ptr wins.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + k) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IdxW'(idx);
            end
        end
    end

endmodule

// File: rtl/regf_wb_sched.sv
// Scoreboard and writeback scheduler for the 32x32 integer register file.
// Stalls issue on RAW/WAW hazards and round-robins writeback sources onto the single
// registered write port. Define REGF_SCHED_PERF_EN to add stall/conflict counters.
module regf_wb_sched
    import regf_pkg::*;
#(
    parameter int unsigned N_WB   = 3,
    parameter int unsigned XLEN_P = XLEN
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   issue_valid,
    input  logic [4:0]             issue_rs1,
    input  logic [4:0]             issue_rs2,
    input  logic [4:0]             issue_rd,
    input  logic                   issue_use_rs1,
    input  logic                   issue_use_rs2,
    input  logic                   issue_wr_rd,
    output logic                   issue_ready,
    input  logic [N_WB-1:0]        wb_valid,
    input  logic [5*N_WB-1:0]      wb_addr,
    input  logic [XLEN_P*N_WB-1:0] wb_data,
    output logic [N_WB-1:0]        wb_ready,
    output logic                   w_enable,
    output logic [4:0]             w_addr,
    output logic [XLEN_P-1:0]      w_data,
    output logic [31:0]            busy,
`ifdef REGF_SCHED_PERF_EN
    output logic [31:0]            perf_stall_cycles,
    output logic [31:0]            perf_wb_conflict_cycles,
`endif
    output logic                   err_spurious
);

    localparam int unsigned IdxW = (N_WB > 1) ? $clog2(N_WB) : 1;

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                w_enable_q;
    reg_idx_t            w_addr_q;
    logic [XLEN_P-1:0]   w_data_q;
    logic                err_q;
    logic [IdxW-1:0]     rr_ptr_q;

    logic [N_WB-1:0]     grant;
    logic [IdxW-1:0]     grant_idx;
    logic                grant_any;
    reg_idx_t            g_addr;
    logic [XLEN_P-1:0]   g_data;
    logic                issue_fire;
    logic                spurious;

    rr_arbiter #(
        .N    (N_WB),
        .IdxW (IdxW)
    ) u_arb (
        .req       (wb_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // Hazard check against the scoreboard; everything is held off during reset.
    always_comb begin
        issue_ready = rstn
                    & ~(issue_use_rs1 & busy_q[issue_rs1])
                    & ~(issue_use_rs2 & busy_q[issue_rs2])
                    & ~(issue_wr_rd   & busy_q[issue_rd]);
        issue_fire  = issue_valid & issue_ready;
        wb_ready    = rstn ? grant : '0;
    end

    // Mux the granted source's address and data.
    always_comb begin
        g_addr = '0;
        g_data = '0;
        for (int unsigned i = 0; i < N_WB; i++) begin
            if (grant[i]) begin
                g_addr = wb_addr[i*5 +: 5];
                g_data = wb_data[i*XLEN_P +: XLEN_P];
            end
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a same-edge set wins.
    always_comb begin
        busy_d = busy_q;
        if (w_enable_q) begin
            busy_d[w_addr_q] = 1'b0;
        end
        if (issue_fire && issue_wr_rd && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
        // A commit to a register nobody is waiting on is a protocol error.
        spurious = w_enable_q && (w_addr_q != '0) && !busy_q[w_addr_q];
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_q     <= '0;
            w_enable_q <= 1'b0;
            w_addr_q   <= '0;
            w_data_q   <= '0;
            err_q      <= 1'b0;
            rr_ptr_q   <= IdxW'(N_WB - 1);
        end else begin
            busy_q     <= busy_d;
            w_enable_q <= grant_any && (g_addr != '0);
            if (grant_any) begin
                w_addr_q <= g_addr;
                w_data_q <= g_data;
                rr_ptr_q <= grant_idx;
            end
            if (spurious) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef REGF_SCHED_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] conflict_cnt_q;

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cnt_q    <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (issue_valid && !issue_ready && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (($countones(wb_valid) > 1) && (conflict_cnt_q != '1)) begin
                conflict_cnt_q <= conflict_cnt_q + 32'd1;
            end
        end
    end

    assign perf_stall_cycles       = stall_cnt_q;
    assign perf_wb_conflict_cycles = conflict_cnt_q;
`endif

    assign w_enable     = w_enable_q;
    assign w_addr       = w_addr_q;
    assign w_data       = w_data_q;
    assign busy         = busy_q;
    assign err_spurious = err_q;

endmodule

// File: tb/tb_regf_wb_sched.sv
// Directed testbench for regf_wb_sched. Perf counter checks compile in with
// REGF_SCHED_PERF_EN.
module tb_regf_wb_sched;

    localparam int unsigned N_WB = 3;
    localparam int unsigned XLEN = 32;

    logic                 clk;
    logic                 rstn;
    logic                 issue_valid;
    logic [4:0]           issue_rs1, issue_rs2, issue_rd;
    logic                 issue_use_rs1, issue_use_rs2, issue_wr_rd;
    logic                 issue_ready;
    logic [N_WB-1:0]      wb_valid;
    logic [5*N_WB-1:0]    wb_addr;
    logic [XLEN*N_WB-1:0] wb_data;
    logic [N_WB-1:0]      wb_ready;
    logic                 w_enable;
    logic [4:0]           w_addr;
    logic [XLEN-1:0]      w_data;
    logic [31:0]          busy;
    logic                 err_spurious;
`ifdef REGF_SCHED_PERF_EN
    logic [31:0]          perf_stall_cycles;
    logic [31:0]          perf_wb_conflict_cycles;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    regf_wb_sched #(
        .N_WB   (N_WB),
        .XLEN_P (XLEN)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_rd      (issue_rd),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_wr_rd   (issue_wr_rd),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .wb_data       (wb_data),
        .wb_ready      (wb_ready),
        .w_enable      (w_enable),
        .w_addr        (w_addr),
        .w_data        (w_data),
        .busy          (busy),
`ifdef REGF_SCHED_PERF_EN
        .perf_stall_cycles       (perf_stall_cycles),
        .perf_wb_conflict_cycles (perf_wb_conflict_cycles),
`endif
        .err_spurious  (err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_issue();
        issue_valid   = 1'b0;
        issue_rs1     = '0;
        issue_rs2     = '0;
        issue_rd      = '0;
        issue_use_rs1 = 1'b0;
        issue_use_rs2 = 1'b0;
        issue_wr_rd   = 1'b0;
    endtask

    task automatic issue_write(input logic [4:0] rd);
        idle_issue();
        issue_valid = 1'b1;
        issue_rd    = rd;
        issue_wr_rd = 1'b1;
    endtask

    task automatic set_src(input int i, input logic [4:0] addr, input logic [31:0] data);
        wb_valid[i]          = 1'b1;
        wb_addr[i*5 +: 5]    = addr;
        wb_data[i*XLEN +: XLEN] = data;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        wb_valid = '0;
        wb_addr  = '0;
        wb_data  = '0;
        idle_issue();
        tick();
        tick();

        // Reset state and gating while in reset
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_wen", 64'(w_enable), 64'h0);
        check("rst_waddr", 64'(w_addr), 64'h0);
        check("rst_wdata", 64'(w_data), 64'h0);
        check("rst_err", 64'(err_spurious), 64'h0);
        issue_write(5'd3);
        set_src(0, 5'd3, 32'h1);
        settle();
        check("rst_issue_ready", 64'(issue_ready), 64'h0);
        check("rst_wb_ready", 64'(wb_ready), 64'h0);
        idle_issue();
        wb_valid = '0;
        rstn = 1'b1;
        tick();

        // RAW: issue rd=5, then a reader of x5 stalls until writeback commits
        issue_write(5'd5);
        settle();
        check("raw_issue_rd5", 64'(issue_ready), 64'h1);
        tick();
        idle_issue();
        issue_valid   = 1'b1;
        issue_rs1     = 5'd5;
        issue_use_rs1 = 1'b1;
        settle();
        check("raw_busy5", 64'(busy), 64'h20);
        check("raw_stall", 64'(issue_ready), 64'h0);
        set_src(0, 5'd5, 32'hDEADBEEF);
        settle();
        check("raw_grant", 64'(wb_ready), 64'h1);
        tick();
        wb_valid = '0;
        check("raw_t1_wen", 64'(w_enable), 64'h1);
        check("raw_t1_waddr", 64'(w_addr), 64'h5);
        check("raw_t1_wdata", 64'(w_data), 64'hDEADBEEF);
        check("raw_t1_stall", 64'(issue_ready), 64'h0);
        tick();
        check("raw_t2_busy", 64'(busy), 64'h0);
        check("raw_t2_ready", 64'(issue_ready), 64'h1);
        check("raw_t2_wen", 64'(w_enable), 64'h0);
        check("raw_t2_waddr_hold", 64'(w_addr), 64'h5);
        idle_issue();

        // WAW on x7; pointer now at source 0 so source 1 wins next
        issue_write(5'd7);
        tick();
        check("waw_busy7", 64'(busy), 64'h80);
        issue_write(5'd7);
        settle();
        check("waw_stall", 64'(issue_ready), 64'h0);
        set_src(1, 5'd7, 32'h77);
        settle();
        check("waw_grant", 64'(wb_ready), 64'h2);
        tick();
        wb_valid = '0;
        check("waw_t1_stall", 64'(issue_ready), 64'h0);
        check("waw_t1_waddr", 64'(w_addr), 64'h7);
        tick();
        check("waw_t2_ready", 64'(issue_ready), 64'h1);
        idle_issue();
        check("waw_err", 64'(err_spurious), 64'h0);

        // Round-robin: reset so source 0 has first priority, busy x1..x3
        do_reset();
        for (int r = 1; r <= 3; r++) begin
            issue_write(5'(r));
            tick();
        end
        idle_issue();
        check("rr_busy", 64'(busy), 64'hE);
        for (int i = 0; i < 3; i++) begin
            set_src(i, 5'(i + 1), 32'h100 + 32'(i));
        end
        for (int k = 0; k < 4; k++) begin
            int g;
            g = k % 3;
            settle();
            check($sformatf("rr_grant%0d", k), 64'(wb_ready), 64'(1 << g));
            tick();
            check($sformatf("rr_wen%0d", k), 64'(w_enable), 64'h1);
            check($sformatf("rr_waddr%0d", k), 64'(w_addr), 64'(g + 1));
            check($sformatf("rr_wdata%0d", k), 64'(w_data), 64'h100 + 64'(g));
        end
        wb_valid = '0;
        // Fourth write hits x1 again after it already committed: spurious
        check("rr_err_before", 64'(err_spurious), 64'h0);
        tick();
        check("rr_err_dup", 64'(err_spurious), 64'h1);
        check("rr_idle_wen", 64'(w_enable), 64'h0);
        check("rr_idle_waddr", 64'(w_addr), 64'h1);
        check("rr_busy_clear", 64'(busy), 64'h0);

        // x0: issue never marks busy, writeback consumed but not written
        do_reset();
        check("x0_err_rst", 64'(err_spurious), 64'h0);
        issue_write(5'd0);
        settle();
        check("x0_issue_ready", 64'(issue_ready), 64'h1);
        tick();
        idle_issue();
        check("x0_busy", 64'(busy), 64'h0);
        set_src(0, 5'd0, 32'h55);
        settle();
        check("x0_grant", 64'(wb_ready), 64'h1);
        tick();
        wb_valid = '0;
        check("x0_wen", 64'(w_enable), 64'h0);
        tick();
        check("x0_err", 64'(err_spurious), 64'h0);

        // Spurious write to x9: proceeds, error sticks
        set_src(1, 5'd9, 32'h99);
        settle();
        check("sp_grant", 64'(wb_ready), 64'h2);
        tick();
        wb_valid = '0;
        check("sp_wen", 64'(w_enable), 64'h1);
        check("sp_waddr", 64'(w_addr), 64'h9);
        check("sp_wdata", 64'(w_data), 64'h99);
        tick();
        check("sp_err", 64'(err_spurious), 64'h1);
        tick();
        check("sp_err_sticky", 64'(err_spurious), 64'h1);

        // Mid-stream reset with a busy register and a pending request
        issue_write(5'd4);
        tick();
        idle_issue();
        check("mr_busy4", 64'(busy), 64'h10);
        set_src(2, 5'd4, 32'h44);
        rstn = 1'b0;
        settle();
        check("mr_wb_ready_gated", 64'(wb_ready), 64'h0);
        tick();
        rstn = 1'b1;
        wb_valid = '0;
        check("mr_busy", 64'(busy), 64'h0);
        check("mr_wen", 64'(w_enable), 64'h0);
        check("mr_err", 64'(err_spurious), 64'h0);

`ifdef REGF_SCHED_PERF_EN
        check("perf_stall_rst", 64'(perf_stall_cycles), 64'h0);
        check("perf_conf_rst", 64'(perf_wb_conflict_cycles), 64'h0);
        issue_write(5'd6);
        tick();
        idle_issue();
        issue_valid   = 1'b1;
        issue_rs2     = 5'd6;
        issue_use_rs2 = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        idle_issue();
        set_src(0, 5'd6, 32'h66);
        set_src(1, 5'd0, 32'h0);
        tick();
        tick();
        wb_valid = '0;
        tick();
        check("perf_stall", 64'(perf_stall_cycles), 64'h4);
        check("perf_conf", 64'(perf_wb_conflict_cycles), 64'h2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
